decode_stage_pipe: RTL

//  Parametrised ID stage for the branch-prediction pipeline. Decodes RV32I subset (ADD, SUB, ADDI,
//  BEQ/BNE/BLT/BGE, JAL) into register indices, sign-extended immediate, op class and precomputed

---
 rtl/decode_stage_pipe_if.sv | 31 +++
 rtl/decode_stage_pipe.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/decode_stage_pipe_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for decode_stage_pipe.
// The slave modport is the decode stage; the master modport is the surrounding pipeline.
interface decode_stage_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr_in;
  logic [XLEN-1:0] pc_in;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] target;
  logic [2:0]      op;
  logic [1:0]      br_cond;
  logic            wb_en;

  modport master (
    output in_valid, instr_in, pc_in, out_ready,
    input  in_ready, out_valid, rs1, rs2, rd, imm, pc_out, target, op, br_cond, wb_en
  );

  modport slave (
    input  in_valid, instr_in, pc_in, out_ready,
    output in_ready, out_valid, rs1, rs2, rd, imm, pc_out, target, op, br_cond, wb_en
  );
endinterface

// File: rtl/decode_stage_pipe.sv
// RV32I-subset decode stage: decodes on accept, buffers decoded entries in a small FIFO
// toward execute, supports flush, and counts accepted unrecognised instructions.
module decode_stage_pipe #(
  parameter int XLEN    = 32,
  parameter int Q_DEPTH = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  decode_stage_pipe_if.slave bus,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam int PTR_W = $clog2(Q_DEPTH);

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_ADD    = 3'd1,
    OP_SUB    = 3'd2,
    OP_ADDI   = 3'd3,
    OP_BRANCH = 3'd4,
    OP_JAL    = 3'd5
  } op_e;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic [2:0]      op;
    logic [1:0]      br_cond;
    logic            wb_en;
  } entry_t;

  entry_t          q_mem [Q_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  entry_t          dec;
  entry_t          head;
  logic            dec_illegal;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;

  assign opcode = bus.instr_in[6:0];
  assign funct3 = bus.instr_in[14:12];
  assign funct7 = bus.instr_in[31:25];
  assign imm_i  = {{(XLEN-12){bus.instr_in[31]}}, bus.instr_in[31:20]};
  assign imm_b  = {{(XLEN-13){bus.instr_in[31]}}, bus.instr_in[31], bus.instr_in[7],
                   bus.instr_in[30:25], bus.instr_in[11:8], 1'b0};
  assign imm_j  = {{(XLEN-21){bus.instr_in[31]}}, bus.instr_in[31], bus.instr_in[19:12],
                   bus.instr_in[20], bus.instr_in[30:21], 1'b0};

  // Unrecognised encodings fall through with every field zero except the PC.
  always_comb begin
    dec         = '0;
    dec_illegal = 1'b1;
    dec.pc      = bus.pc_in;
    case (opcode)
      7'b0110011: begin
        if (funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) begin
          dec.op      = funct7[5] ? OP_SUB : OP_ADD;
          dec.rs1     = bus.instr_in[19:15];
          dec.rs2     = bus.instr_in[24:20];
          dec.rd      = bus.instr_in[11:7];
          dec.wb_en   = (bus.instr_in[11:7] != 5'd0);
          dec_illegal = 1'b0;
        end
      end
      7'b0010011: begin
        if (funct3 == 3'b000) begin
          dec.op      = OP_ADDI;
          dec.rs1     = bus.instr_in[19:15];
          dec.rd      = bus.instr_in[11:7];
          dec.imm     = imm_i;
          dec.wb_en   = (bus.instr_in[11:7] != 5'd0);
          dec_illegal = 1'b0;
        end
      end
      7'b1100011: begin
        if (funct3[1] == 1'b0) begin
          dec.op      = OP_BRANCH;
          dec.rs1     = bus.instr_in[19:15];
          dec.rs2     = bus.instr_in[24:20];
          dec.imm     = imm_b;
          dec.target  = bus.pc_in + imm_b;
          dec.br_cond = {funct3[2], funct3[0]};
          dec_illegal = 1'b0;
        end
      end
      7'b1101111: begin
        dec.op      = OP_JAL;
        dec.rd      = bus.instr_in[11:7];
        dec.imm     = imm_j;
        dec.target  = bus.pc_in + imm_j;
        dec.wb_en   = (bus.instr_in[11:7] != 5'd0);
        dec_illegal = 1'b0;
      end
      default: ;
    endcase
  end

  assign full         = (count == (PTR_W+1)'(Q_DEPTH));
  assign empty        = (count == '0);
  assign bus.out_valid = !empty;
  assign bus.in_ready  = !full || (bus.out_valid && bus.out_ready) || flush;
  assign push          = bus.in_valid && bus.in_ready && !flush;
  assign pop           = bus.out_valid && bus.out_ready && !flush;

  // Idle head drives zeros so execute never sees stale fields.
  assign head        = empty ? '0 : q_mem[rd_ptr];
  assign bus.rs1     = head.rs1;
  assign bus.rs2     = head.rs2;
  assign bus.rd      = head.rd;
  assign bus.imm     = head.imm;
  assign bus.pc_out  = head.pc;
  assign bus.target  = head.target;
  assign bus.op      = head.op;
  assign bus.br_cond = head.br_cond;
  assign bus.wb_en   = head.wb_en;

  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wr_ptr] <= dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      illegal_cnt <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (push && dec_illegal && illegal_cnt != '1) begin
        illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
    end
  end
endmodule
